// File: rtl/aes_eth_tx_framer.sv
// AES ciphertext to Avalon-ST framer: prepends a padded MAC header to
// each run of 128-bit blocks and emits them as 32-bit TSE words.
module aes_eth_tx_framer #(
  parameter int AES_DATA_WIDTH    = 128,
  parameter int MAC_STREAM_WIDTH  = 32,
  parameter int MAX_BLOCKS        = 64,
  parameter int WORD_COUNTER_SIZE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [47:0]                 src_mac,
  input  logic [47:0]                 dst_mac,
  input  logic [AES_DATA_WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [MAC_STREAM_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [1:0]                  out_empty,
  output logic [31:0]                 frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_WAIT
  } state_t;

  state_t                         r_state;
  logic [1:0]                     r_idx;
  logic [WORD_COUNTER_SIZE-1:0]   r_cnt;
  logic [AES_DATA_WIDTH-1:0]      r_blk;
  logic                           r_last;
  logic [47:0]                    r_src;
  logic [47:0]                    r_dst;
  logic [31:0]                    r_frames;

  logic                           w_end;
  logic                           w_ihs;
  logic                           w_ohs;
  logic [127:0]                   w_hdr;
  logic [127:0]                   w_unit;

  assign w_end = r_last ||
    (r_cnt == WORD_COUNTER_SIZE'(MAX_BLOCKS));
  assign w_hdr = {16'h0000, r_dst, r_src, 16'h0800};
  assign w_unit = (r_state == S_HDR) ? w_hdr : r_blk;
  assign w_ihs = in_valid && in_ready;
  assign w_ohs = out_valid && out_ready;

  // Only in_ready looks at a live input (out_ready); the rest is Moore.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE:  in_ready = 1'b1;
        S_WAIT:  in_ready = 1'b1;
        S_PAY:   in_ready = (r_idx == 2'd3) && out_ready && !w_end;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign out_valid = (r_state == S_HDR) || (r_state == S_PAY);
  assign out_data  = out_valid ? w_unit[{~r_idx, 5'd0} +: 32] : '0;
  assign out_sop   = (r_state == S_HDR) && (r_idx == 2'd0);
  assign out_eop   = (r_state == S_PAY) && (r_idx == 2'd3) && w_end;
  assign out_empty = 2'd0;
  assign frame_cnt = r_frames;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      r_blk    <= '0;
      r_last   <= 1'b0;
      r_src    <= '0;
      r_dst    <= '0;
      r_frames <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ihs) begin
            r_blk   <= in_data;
            r_last  <= in_last;
            r_src   <= src_mac;
            r_dst   <= dst_mac;
            r_cnt   <= WORD_COUNTER_SIZE'(1);
            r_idx   <= 2'd0;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_ohs) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_PAY;
          end
        end
        S_PAY: begin
          if (w_ohs) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if (w_end) begin
                r_frames <= r_frames + 32'd1;
                r_state  <= S_IDLE;
              end else if (w_ihs) begin
                r_blk  <= in_data;
                r_last <= in_last;
                r_cnt  <= r_cnt + 1'b1;
              end else begin
                r_state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (w_ihs) begin
            r_blk   <= in_data;
            r_last  <= in_last;
            r_cnt   <= r_cnt + 1'b1;
            r_idx   <= 2'd0;
            r_state <= S_PAY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_eth_tx_framer.sv
// Randomised bench for aes_eth_tx_framer: a frame-level model builds
// the expected word stream from every accepted block.
module tb_aes_eth_tx_framer;

  localparam int MAXB = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [47:0]  src_mac = '0;
  logic [47:0]  dst_mac = '0;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_sop;
  logic         out_eop;
  logic [1:0]   out_empty;
  logic [31:0]  frame_cnt;

  aes_eth_tx_framer #(.MAX_BLOCKS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .src_mac(src_mac), .dst_mac(dst_mac),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected stream: {sop, eop, data}
  logic [33:0] expq[$];
  logic [31:0] wlog[$];
  bit          in_frame = 0;
  int          fblk = 0;
  int          m_frames = 0;
  int          hs_cnt = 0;
  int          sop_cnt = 0;
  longint      cyc = 0;
  longint      sop_cyc = 0;
  longint      eop_cyc = 0;

  function automatic void model_push(input logic [127:0] d, input bit l,
                                     input logic [47:0] dm,
                                     input logic [47:0] sm);
    logic [127:0] h;
    bit           e;
    h = {16'h0000, dm, sm, 16'h0800};
    if (!in_frame) begin
      for (int i = 0; i < 4; i++)
        expq.push_back({1'(i == 0), 1'b0, h[127-32*i -: 32]});
      in_frame = 1;
      fblk = 0;
    end
    fblk++;
    e = l || (fblk == MAXB);
    for (int i = 0; i < 4; i++)
      expq.push_back({1'b0, 1'(e && i == 3), d[127-32*i -: 32]});
    if (e) in_frame = 0;
  endfunction

  bit          prev_stall = 0;
  logic [33:0] prev_out;
  logic [33:0] e_w;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      expq.delete();
      in_frame = 0;
      m_frames = 0;
      prev_stall = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
    end else begin
      chk("frame_cnt", frame_cnt, m_frames);
      chk("out_empty", out_empty, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_word", {out_sop, out_eop, out_data}, prev_out);
      end
      if (in_valid && in_ready)
        model_push(in_data, in_last, dst_mac, src_mac);
      if (out_valid && in_ready)
        chk("ready_needs_out_ready", out_ready, 1);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", {out_sop, out_eop, out_data}, 34'h0);
        end else begin
          e_w = expq.pop_front();
          chk("word", {out_sop, out_eop, out_data}, e_w);
        end
        if (out_sop) begin
          sop_cnt++;
          sop_cyc = cyc;
        end
        if (out_eop) begin
          m_frames++;
          eop_cyc = cyc;
        end
        hs_cnt++;
        wlog.push_back(out_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {out_sop, out_eop, out_data};
    end
  end

  int rmode = 0;
  int pat = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        out_ready = (pat % 4 == 0) || (pat % 4 == 3);
        pat++;
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic send(input logic [127:0] d, input bit l);
    int t;
    t = 0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 3000) begin
      t++;
      @(negedge clk);
    end
    chk("drain_timeout", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [31:0]  lit[8];
  logic [127:0] blk;
  int s0, f0, h0, t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", out_data, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single block, literal words
    dst_mac = 48'h001122334455;
    src_mac = 48'h66778899AABB;
    lit = '{32'h00000011, 32'h22334455, 32'h66778899, 32'hAABB0800,
            32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    wlog.delete();
    s0 = sop_cnt;
    send(128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b1);
    drain();
    chk("single_len", wlog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wlog.size()) chk("single_word", wlog[i], lit[i]);
    chk("single_sop", sop_cnt - s0, 1);
    chk("single_eop_pos", eop_cyc - sop_cyc, 7);
    repeat (2) @(negedge clk);
    chk("single_frame_cnt", frame_cnt, 1);
    @(posedge clk);
    #1;

    // Three back-to-back blocks, no bubbles
    s0 = sop_cnt;
    for (int i = 0; i < 3; i++) send(rnd128(), i == 2);
    drain();
    chk("b2b_span", eop_cyc - sop_cyc, 15);
    chk("b2b_sop", sop_cnt - s0, 1);

    // Backpressure pattern 1,0,0,1
    pat = 0;
    rmode = 2;
    send(rnd128(), 1'b0);
    send(rnd128(), 1'b1);
    drain();
    rmode = 0;
    @(posedge clk);
    #1;

    // Forced EOP at MAXB
    f0 = m_frames;
    s0 = sop_cnt;
    for (int i = 0; i < 4; i++) send(rnd128(), i == 3);
    drain();
    chk("forced_frames", m_frames - f0, 2);
    chk("forced_sops", sop_cnt - s0, 2);

    // Starved input
    s0 = sop_cnt;
    h0 = hs_cnt;
    send(rnd128(), 1'b0);
    t = 0;
    while (hs_cnt < h0 + 8 && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("starve_words", hs_cnt - h0, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("starve_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(rnd128(), 1'b1);
    drain();
    chk("starve_sops", sop_cnt - s0, 1);

    // Reset during payload word 2
    blk = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    send(blk, 1'b1);
    repeat (6) @(posedge clk);
    #2;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_word", out_data, 32'h12345678);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    s0 = sop_cnt;
    send(rnd128(), 1'b1);
    drain();
    repeat (2) @(negedge clk);
    chk("post_rst_frame_cnt", frame_cnt, 1);
    chk("post_rst_sop", sop_cnt - s0, 1);
    @(posedge clk);
    #1;

    // Random traffic
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 7) == 0) begin
        dst_mac = {$urandom, $urandom};
        src_mac = {$urandom, $urandom};
      end
      send(rnd128(), $urandom_range(0, 3) == 0);
    end
    send(rnd128(), 1'b1);
    drain();
    rmode = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
